// File: rtl/v20_bus_master.sv
// V20 minimum-mode bus initiator: runs T1..T4 (plus Tw) memory/IO cycles from a simple
// request port, producing the multiplexed AD/AH, ALE, DT/R, IO/M, SSO and bus clock.
module v20_bus_master #(
    parameter int unsigned CLK_DIV  = 1,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iReq,
    input  logic [19:0] iAddr,
    input  logic [7:0]  iData,
    input  logic        iWr,
    input  logic        iIo,
    output logic        oBusy,
    output logic        oAck,
    output logic [7:0]  oData,
    output logic        oTimeout,
    output logic        oBusClk,
    output logic        oAle,
    output logic [11:0] oAh,
    output logic [7:0]  oAdOut,
    output logic        oAdOe,
    input  logic [7:0]  iAdIn,
    output logic        oDtr,
    output logic        oIom,
    output logic        oSso,
    input  logic        iReady
);

    localparam int unsigned PHASES = 2 * CLK_DIV;
    localparam int unsigned CW     = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(PHASES - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV);
    localparam logic [7:0]    WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StT1,
        StT2,
        StT3,
        StTw,
        StT4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [7:0]    wait_q, wait_d;
    logic [19:0]   addr_q;
    logic [7:0]    wdata_q;
    logic          wr_q;
    logic          io_q;
    logic [7:0]    rdata_q;
    logic          abort_q;
    logic [7:0]    data_q;
    logic          ack_q;
    logic          timeout_q;
    logic          busy_q;

    logic tick;
    logic load;
    logic capture;
    logic abort;
    logic done;
    logic active;

    assign tick = (cnt_q == CNT_LAST);

    // Free-running phase counter; every state change is gated by tick.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= StIdle;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        load    = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick && iReq) begin
                    state_d = StT1;
                    load    = 1'b1;
                end
            end
            StT1: begin
                if (tick) state_d = StT2;
            end
            StT2: begin
                if (tick) state_d = StT3;
            end
            StT3: begin
                wait_d = '0;
                if (tick) begin
                    if (iReady) begin
                        state_d = StT4;
                        capture = 1'b1;
                    end else begin
                        state_d = StTw;
                    end
                end
            end
            StTw: begin
                if (tick) begin
                    wait_d = wait_q + 8'd1;
                    if (iReady) begin
                        state_d = StT4;
                        capture = 1'b1;
                    end else if (wait_q == WAIT_LAST) begin
                        // Responder never became ready: give up and finish the cycle.
                        state_d = StT4;
                        abort   = 1'b1;
                    end
                end
            end
            StT4: begin
                if (tick) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            io_q    <= 1'b0;
        end else if (load) begin
            addr_q  <= iAddr;
            wdata_q <= iData;
            wr_q    <= iWr;
            io_q    <= iIo;
        end
    end

    // Read data is staged in rdata_q so oData only changes together with oAck.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            rdata_q <= '0;
            abort_q <= 1'b0;
        end else if (load) begin
            abort_q <= 1'b0;
        end else if (capture) begin
            rdata_q <= iAdIn;
            abort_q <= 1'b0;
        end else if (abort) begin
            rdata_q <= 8'hFF;
            abort_q <= 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            data_q    <= '0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ack_q     <= done;
            timeout_q <= done & abort_q;
            if (done) begin
                data_q <= rdata_q;
            end
            if (load) begin
                busy_q <= 1'b1;
            end else if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign active = (state_q != StIdle);

    always_comb begin
        oBusClk = (cnt_q < CNT_HALF);
        oAle    = (state_q == StT1) && (cnt_q < CNT_HALF);
        oAh     = active ? addr_q[19:8] : 12'h000;
        oDtr    = active & wr_q;
        oIom    = active & io_q;
        oSso    = ~active;
        oAdOe   = 1'b0;
        oAdOut  = 8'h00;
        if (state_q == StT1) begin
            oAdOe  = 1'b1;
            oAdOut = addr_q[7:0];
        end else if (active && wr_q) begin
            oAdOe  = 1'b1;
            oAdOut = wdata_q;
        end
    end

    assign oBusy    = busy_q;
    assign oAck     = ack_q;
    assign oData    = data_q;
    assign oTimeout = timeout_q;

endmodule

// File: tb/tb_v20_bus_master.sv
// Randomised scoreboard bench for v20_bus_master with an in-bench bus responder (memory +
// IO space) that decodes the multiplexed bus and inserts a requested number of waits.
module tb_v20_bus_master;

    localparam int unsigned CLK_DIV  = 1;
    localparam int unsigned MAX_WAIT = 15;

    logic        iClk;
    logic        iRstN;
    logic        iReq;
    logic [19:0] iAddr;
    logic [7:0]  iData;
    logic        iWr;
    logic        iIo;
    logic        oBusy;
    logic        oAck;
    logic [7:0]  oData;
    logic        oTimeout;
    logic        oBusClk;
    logic        oAle;
    logic [11:0] oAh;
    logic [7:0]  oAdOut;
    logic        oAdOe;
    logic [7:0]  iAdIn;
    logic        oDtr;
    logic        oIom;
    logic        oSso;
    logic        iReady;

    v20_bus_master #(
        .CLK_DIV (CLK_DIV),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .iClk    (iClk),
        .iRstN   (iRstN),
        .iReq    (iReq),
        .iAddr   (iAddr),
        .iData   (iData),
        .iWr     (iWr),
        .iIo     (iIo),
        .oBusy   (oBusy),
        .oAck    (oAck),
        .oData   (oData),
        .oTimeout(oTimeout),
        .oBusClk (oBusClk),
        .oAle    (oAle),
        .oAh     (oAh),
        .oAdOut  (oAdOut),
        .oAdOe   (oAdOe),
        .iAdIn   (iAdIn),
        .oDtr    (oDtr),
        .oIom    (oIom),
        .oSso    (oSso),
        .iReady  (iReady)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic [19:0] addr;
        logic [7:0]  wdata;
        bit          wr;
        bit          io;
        logic [7:0]  exp_rd;
        bit          chk_rd;
        bit          tmo;
        int          lat;
    } txn_t;

    txn_t       sb[$];
    txn_t       mon_t;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         acc_cnt = 0;
    int         ack_cnt = 0;
    int         acc_cyc = 0;
    int         ack_cyc = 0;
    int         ts = 99;
    int         ale_cnt = 0;
    int         nwait = 0;
    int         bus_key = 0;
    bit         bc_prev = 1'b1;
    bit         busy_prev = 1'b0;
    logic [7:0] bus_mem[int];
    logic [7:0] ref_mem[int];

    // Contents of a location nobody has written yet.
    function automatic logic [7:0] dflt(input logic [20:0] k);
        return k[7:0] ^ k[15:8] ^ {3'b000, k[20:16]} ^ 8'h3C;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Responder, bus-level checker and completion monitor, all sampled on the falling edge.
    always @(negedge iClk) begin
        cyc++;
        if (!iRstN) begin
            busy_prev = 1'b0;
            bc_prev   = 1'b1;
            ts        = 99;
            iReady    = 1'b1;
            iAdIn     = 8'h00;
        end else begin
            // ts: T-state index since ALE (0 = T1, 2 = T3, 3+ = Tw/T4)
            if (oAle) begin
                ts      = 0;
                bus_key = {11'b0, oIom, oAh, oAdOut};
            end else if (oBusClk && !bc_prev && ts < 1000) begin
                ts++;
            end
            bc_prev = oBusClk;
            iReady  = !(oBusy && ts >= 2 && (ts - 2) < nwait);
            iAdIn   = bus_mem.exists(bus_key) ? bus_mem[bus_key] : dflt(bus_key[20:0]);
            if (oBusy && ts >= 1 && oDtr && oAdOe) bus_mem[bus_key] = oAdOut;

            if (oBusy && !busy_prev) begin
                acc_cnt++;
                acc_cyc = cyc;
                ale_cnt = 0;
            end
            busy_prev = oBusy;
            if (oAle) ale_cnt++;

            check("sso_vs_busy", {31'b0, oSso}, {31'b0, !oBusy});
            if (oBusy && sb.size() > 0) begin
                mon_t = sb[0];
                check("ah", {20'b0, oAh}, {20'b0, mon_t.addr[19:8]});
                check("dtr_iom", {30'b0, oDtr, oIom}, {30'b0, mon_t.wr, mon_t.io});
                if (ts == 0) begin
                    check("t1_ad", {23'b0, oAdOe, oAdOut}, {23'b0, 1'b1, mon_t.addr[7:0]});
                end else if (mon_t.wr) begin
                    check("wr_ad", {23'b0, oAdOe, oAdOut}, {23'b0, 1'b1, mon_t.wdata});
                end else begin
                    check("rd_oe", {31'b0, oAdOe}, 32'd0);
                end
            end else if (!oBusy) begin
                check("idle_bus", {16'b0, oAle, oAdOe, oAh, oDtr, oIom}, 32'd0);
            end

            if (oAck) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    mon_t = sb.pop_front();
                    check("ack_timeout", {31'b0, oTimeout}, {31'b0, mon_t.tmo});
                    check("ack_latency", cyc - acc_cyc, mon_t.lat);
                    check("ale_width", ale_cnt, CLK_DIV);
                    check("busy_at_ack", {31'b0, oBusy}, 32'd0);
                    if (mon_t.chk_rd) check("rd_data", {24'b0, oData}, {24'b0, mon_t.exp_rd});
                end
                ack_cnt++;
                ack_cyc = cyc;
            end else begin
                check("timeout_without_ack", {31'b0, oTimeout}, 32'd0);
            end
        end
    end

    task automatic wait_neg();
        @(negedge iClk);
        #1;
    endtask

    // Reference model: responder stalls nw ready samples; the master gives up after
    // MAX_WAIT wait states if still not ready. A T-state is 2*CLK_DIV clocks.
    task automatic push_txn(input logic [19:0] addr, input logic [7:0] data, input bit wr,
                            input bit io, input int nw);
        txn_t t;
        int   key;
        int   tw;
        key      = {11'b0, io, addr};
        tw       = (nw > int'(MAX_WAIT)) ? int'(MAX_WAIT) : nw;
        t.addr   = addr;
        t.wdata  = data;
        t.wr     = wr;
        t.io     = io;
        t.tmo    = (nw > int'(MAX_WAIT));
        t.lat    = 8 * CLK_DIV + 2 * CLK_DIV * tw;
        t.chk_rd = !wr;
        t.exp_rd = 8'h00;
        if (wr) begin
            ref_mem[key] = data;
        end else if (t.tmo) begin
            t.exp_rd = 8'hFF;
        end else begin
            t.exp_rd = ref_mem.exists(key) ? ref_mem[key] : dflt(key[20:0]);
        end
        sb.push_back(t);
    endtask

    task automatic drive(input logic [19:0] addr, input logic [7:0] data, input bit wr,
                         input bit io);
        iReq  = 1'b1;
        iAddr = addr;
        iData = data;
        iWr   = wr;
        iIo   = io;
    endtask

    task automatic scramble();
        iReq  = 1'b0;
        iAddr = 20'($urandom);
        iData = 8'($urandom);
        iWr   = 1'($urandom);
        iIo   = 1'($urandom);
    endtask

    task automatic wait_accept(input int prev);
        int n;
        n = 0;
        while (acc_cnt == prev && n < 100) begin
            wait_neg();
            n++;
        end
        if (acc_cnt == prev) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            wait_neg();
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        wait_neg();
    endtask

    task automatic do_txn(input logic [19:0] addr, input logic [7:0] data, input bit wr,
                          input bit io, input int nw);
        int p;
        nwait = nw;
        push_txn(addr, data, wr, io, nw);
        p = acc_cnt;
        drive(addr, data, wr, io);
        wait_accept(p);
        scramble();
        wait_drain();
    endtask

    task automatic rst_check(input string tag);
        check({tag, "_bus"}, {8'b0, oAle, oAdOe, oAh, oAdOut, oDtr, oIom}, 32'd0);
        check({tag, "_status"}, {27'b0, oSso, oBusClk, oBusy, oAck, oTimeout}, 32'b11000);
        check({tag, "_data"}, {24'b0, oData}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (tests %0d)", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int a;
        int n;
        int r;
        iRstN = 1'b0;
        iReq  = 1'b0;
        iAddr = '0;
        iData = '0;
        iWr   = 1'b0;
        iIo   = 1'b0;
        #2;
        rst_check("reset");
        repeat (3) wait_neg();
        iRstN = 1'b1;
        wait_neg();

        // Memory write, then IO read, then the same read with 3 waits, then timeout.
        do_txn(20'hB0123, 8'h5A, 1'b1, 1'b0, 0);
        bus_mem[{11'b0, 1'b1, 20'h003DA}] = 8'hC3;
        ref_mem[{11'b0, 1'b1, 20'h003DA}] = 8'hC3;
        do_txn(20'h003DA, 8'h00, 1'b0, 1'b1, 0);
        do_txn(20'h003DA, 8'h00, 1'b0, 1'b1, 3);
        do_txn(20'h04000, 8'h00, 1'b0, 1'b0, 200);
        do_txn(20'h04000, 8'h00, 1'b0, 1'b0, 0);

        // Back-to-back: second request held high through the first's oAck.
        nwait = 0;
        push_txn(20'h11111, 8'h3E, 1'b1, 1'b0, 0);
        push_txn(20'h11111, 8'h00, 1'b0, 1'b0, 0);
        p = acc_cnt;
        drive(20'h11111, 8'h3E, 1'b1, 1'b0);
        wait_accept(p);
        p = acc_cnt;
        drive(20'h11111, 8'h00, 1'b0, 1'b0);
        wait_accept(p);
        check("b2b_gap", acc_cyc - ack_cyc, 2 * CLK_DIV);
        scramble();
        wait_drain();

        // Reset during T2 of a write: no ack, then a fresh cycle completes.
        nwait = 0;
        push_txn(20'h0F0F0, 8'h77, 1'b1, 1'b0, 0);
        p = acc_cnt;
        drive(20'h0F0F0, 8'h77, 1'b1, 1'b0);
        wait_accept(p);
        scramble();
        n = 0;
        while (ts != 1 && n < 20) begin
            wait_neg();
            n++;
        end
        check("reach_t2", ts, 32'd1);
        iRstN = 1'b0;
        #1;
        rst_check("midreset");
        sb.delete();
        a = ack_cnt;
        repeat (2) wait_neg();
        iRstN = 1'b1;
        repeat (20) wait_neg();
        check("no_ack_after_reset", ack_cnt, a);
        do_txn(20'h0F0F0, 8'h78, 1'b1, 1'b0, 0);
        do_txn(20'h0F0F0, 8'h00, 1'b0, 1'b0, 0);

        // Loopback write then read back.
        do_txn(20'h12345, 8'hA5, 1'b1, 1'b0, 0);
        do_txn(20'h12345, 8'h00, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5) n = 0;
            else if (r < 9) n = r - 4;
            else n = int'(MAX_WAIT) + int'($urandom_range(0, 2));
            do_txn(20'h2A000 | 20'($urandom_range(0, 7)), 8'($urandom), 1'($urandom),
                   1'($urandom), n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
